// File: rtl/axis_tlast_packetizer.sv
// rtl/axis_tlast_packetizer.sv - AXI-Stream packetizer with programmable TLAST framing, flush and skid-buffered output
//
// Frames an incoming stream into packets of pkt_len beats (0 treated as 1),
// with an early-termination flush. The output stage is an output register
// plus one skid register, so both sides use real valid/ready handshakes and
// the stream runs at one beat per cycle when the sink is always ready.
//
// Ports:
//   ps_clk, rst          clock, synchronous active-high reset
//   pkt_len              beats per packet, sampled on a packet's first beat
//   flush                single-cycle request to end the current packet
//   s_axis_*             upstream slave stream (tdata/tvalid/tready)
//   m_axis_*             downstream master stream (tdata/tkeep/tlast/tvalid/tready)
//   beat_cnt             beats accepted so far in the current packet
//   pkt_cnt              packets completed on the output (wrapping)

module axis_tlast_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    ps_clk,
    input  logic                    rst,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [LEN_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_cnt
);

    // Output register and skid register
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_skid_valid;
    logic                  r_skid_last;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_ready;

    // Framing state
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_len_q;
    logic                  r_flush_pending;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;

    logic                  w_accept;
    logic                  w_out_fire;
    logic                  w_out_free;
    logic [LEN_WIDTH-1:0]  w_len_eff;
    logic [LEN_WIDTH-1:0]  w_beat_next;
    logic                  w_last;

    assign w_accept   = s_axis_tvalid && r_ready;
    assign w_out_fire = r_out_valid && m_axis_tready;
    // Output register can take a new beat this cycle
    assign w_out_free = !r_out_valid || m_axis_tready;

    // On the first beat of a packet the live pkt_len applies; afterwards the
    // latched length, so mid-packet length changes wait for the next packet.
    assign w_len_eff   = (r_beat_cnt == '0) ? ((pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len)
                                            : r_len_q;
    // beat_cnt stays below len_q, so the increment cannot overflow even for
    // an all-ones length.
    assign w_beat_next = r_beat_cnt + LEN_WIDTH'(1);
    assign w_last      = (w_beat_next == w_len_eff) || r_flush_pending || flush;

    always_ff @(posedge ps_clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_data      <= '0;
            r_skid_valid    <= 1'b0;
            r_skid_last     <= 1'b0;
            r_skid_data     <= '0;
            r_ready         <= 1'b0;
            r_beat_cnt      <= '0;
            r_len_q         <= '0;
            r_flush_pending <= 1'b0;
            r_pkt_cnt       <= '0;
        end else begin
            // Datapath: ready is registered as "skid empty next cycle", so an
            // accept only ever happens while the skid register is empty.
            r_ready <= 1'b1;
            if (r_skid_valid) begin
                if (w_out_free) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_ready <= 1'b0;
                end
            end else if (w_accept) begin
                if (w_out_free) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= s_axis_tdata;
                    r_out_last  <= w_last;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= s_axis_tdata;
                    r_skid_last  <= w_last;
                    r_ready      <= 1'b0;
                end
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end

            // Framing
            if (w_accept) begin
                if (r_beat_cnt == '0) begin
                    r_len_q <= w_len_eff;
                end
                if (w_last) begin
                    r_beat_cnt      <= '0;
                    r_flush_pending <= 1'b0;
                end else begin
                    r_beat_cnt <= w_beat_next;
                end
            end else if (flush && (r_beat_cnt != '0)) begin
                // Flush between beats ends the packet on its next beat;
                // a flush with no open packet is dropped.
                r_flush_pending <= 1'b1;
            end

            if (w_out_fire && r_out_last) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign s_axis_tready = r_ready;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_valid;
    assign beat_cnt      = r_beat_cnt;
    assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_axis_tlast_packetizer.sv
// tb/tb_axis_tlast_packetizer.sv - scoreboard bench for axis_tlast_packetizer

module tb_axis_tlast_packetizer;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 4;

    logic            ps_clk = 1'b0;
    logic            rst;
    logic [LW-1:0]   pkt_len;
    logic            flush;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tkeep;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [LW-1:0]   beat_cnt;
    logic [CW-1:0]   pkt_cnt;

    always #5 ps_clk = ~ps_clk;

    axis_tlast_packetizer #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .CNT_WIDTH (CW)
    ) dut (
        .ps_clk       (ps_clk),
        .rst          (rst),
        .pkt_len      (pkt_len),
        .flush        (flush),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .beat_cnt     (beat_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] out_log[$];
    logic [DW-1:0] last_log[$];
    logic [DW-1:0] want[$];

    // Reference framing state
    logic [LW-1:0] m_bc   = '0;
    logic [LW-1:0] m_len  = '0;
    logic          m_fp   = 1'b0;
    logic [CW-1:0] m_pkt  = '0;

    bit            mon_en     = 1'b0;
    bit            prev_rst   = 1'b0;
    bit            prev_stall = 1'b0;
    bit            prev_acc   = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    int cyc = 0;
    int t0;
    always @(posedge ps_clk) cyc++;

    // Sink ready: held value or the 1,0,0,1 pattern
    bit   bp_mode    = 1'b0;
    logic hold_ready = 1'b1;
    int   bp_idx     = 0;
    always @(posedge ps_clk) begin
        #2;
        if (bp_mode) begin
            m_tready = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
            bp_idx++;
        end else begin
            m_tready = hold_ready;
        end
    end

    // Monitor: values seen at the negedge are those the next posedge uses
    always @(negedge ps_clk) begin : monitor
        beat_t         b;
        logic [LW-1:0] le;
        logic          lst;
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                m_bc       = '0;
                m_fp       = 1'b0;
                m_pkt      = '0;
                prev_rst   = 1'b1;
                prev_stall = 1'b0;
                prev_acc   = 1'b0;
            end else begin
                chk("beat_cnt", 64'(beat_cnt), 64'(m_bc));
                chk("s_tready", 64'(s_tready), 64'(!prev_rst && (exp_q.size() < 2)));
                chk("tkeep", 64'(m_tkeep), 64'(4'hf));
                if (prev_acc) chk("latency", 64'(m_tvalid), 64'(1));
                if (prev_stall) begin
                    chk("stall_valid", 64'(m_tvalid), 64'(1));
                    chk("stall_data", 64'(m_tdata), 64'(prev_data));
                    chk("stall_last", 64'(m_tlast), 64'(prev_last));
                end
                if (exp_q.size() == 0) chk("idle_valid", 64'(m_tvalid), 64'(0));
                if (m_tvalid && m_tready && (exp_q.size() > 0)) begin
                    b = exp_q.pop_front();
                    chk("out_data", 64'(m_tdata), 64'(b.data));
                    chk("out_last", 64'(m_tlast), 64'(b.last));
                    out_log.push_back(m_tdata);
                    if (m_tlast) last_log.push_back(m_tdata);
                    if (b.last) m_pkt = m_pkt + 1'b1;
                end
                if (s_tvalid && s_tready) begin
                    le  = (m_bc == '0) ? ((pkt_len == '0) ? LW'(1) : pkt_len) : m_len;
                    lst = ((m_bc + LW'(1)) == le) || m_fp || flush;
                    if (m_bc == '0) m_len = le;
                    b.data = s_tdata;
                    b.last = lst;
                    exp_q.push_back(b);
                    if (lst) begin
                        m_bc = '0;
                        m_fp = 1'b0;
                    end else begin
                        m_bc = m_bc + LW'(1);
                    end
                end else if (flush && (m_bc != '0)) begin
                    m_fp = 1'b1;
                end
                prev_rst   = 1'b0;
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
                prev_acc   = s_tvalid && s_tready;
            end
        end
    end

    task automatic step();
        @(posedge ps_clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic fl);
        bit got = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        flush    = fl;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge ps_clk);
            got = s_tready;
            step();
        end
        chk("send_accept", 64'(got), 64'(1));
        s_tvalid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n, input logic fl);
        s_tvalid = 1'b0;
        flush    = fl;
        repeat (n) step();
        flush    = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ps_clk);
            done = (exp_q.size() == 0) && !m_tvalid;
            if (done) break;
        end
        chk("drain", 64'(done), 64'(1));
        step();
    endtask

    task automatic cmp_log(input string tag, input bit use_out);
        int n;
        logic [DW-1:0] g;
        n = use_out ? out_log.size() : last_log.size();
        chk({tag, "_count"}, 64'(n), 64'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            g = 'x;
            if (i < n) g = use_out ? out_log[i] : last_log[i];
            chk(tag, 64'(g), 64'(want[i]));
        end
    endtask

    task automatic clear_logs();
        out_log.delete();
        last_log.delete();
        want.delete();
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        flush    = 1'b0;
        pkt_len  = LW'(4);
        repeat (3) step();
        @(negedge ps_clk);
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        chk("rst_tdata", 64'(m_tdata), 64'(0));
        chk("rst_tready", 64'(s_tready), 64'(0));
        chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_tkeep", 64'(m_tkeep), 64'(4'hf));
        step();
        rst = 1'b0;
        @(negedge ps_clk);
        chk("post_rst_ready_low", 64'(s_tready), 64'(0));
        step();
        mon_en = 1'b1;
        @(negedge ps_clk);
        chk("ready_rise", 64'(s_tready), 64'(1));
        step();

        // Streaming, pkt_len=4
        clear_logs();
        pkt_len = LW'(4);
        t0 = cyc;
        for (int i = 0; i < 12; i++) send_beat(DW'(i), 1'b0);
        chk("t1_no_bubbles", 64'(cyc - t0), 64'(12));
        drain();
        want = '{32'd3, 32'd7, 32'd11};
        cmp_log("t1_last", 1'b0);
        want.delete();
        for (int i = 0; i < 12; i++) want.push_back(DW'(i));
        cmp_log("t1_out", 1'b1);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(3));

        // Backpressure, pkt_len=3
        clear_logs();
        pkt_len = LW'(3);
        bp_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send_beat(DW'(100 + i), 1'b0);
            idle($urandom_range(0, 2), 1'b0);
        end
        drain();
        bp_mode = 1'b0;
        for (int k = 0; k < 10; k++) want.push_back(DW'(102 + 3 * k));
        cmp_log("t2_last", 1'b0);
        want.delete();
        for (int i = 0; i < 30; i++) want.push_back(DW'(100 + i));
        cmp_log("t2_out", 1'b1);
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));

        // Flush, pkt_len=8
        clear_logs();
        pkt_len = LW'(8);
        for (int i = 0; i < 5; i++) send_beat(DW'(200 + i), 1'b0);
        @(negedge ps_clk);
        chk("t3_bc5", 64'(beat_cnt), 64'(5));
        step();
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        send_beat(DW'(205), 1'b0);
        @(negedge ps_clk);
        chk("t3_bc_after_flush", 64'(beat_cnt), 64'(0));
        step();
        for (int i = 0; i < 8; i++) send_beat(DW'(210 + i), 1'b0);
        send_beat(DW'(220), 1'b0);
        send_beat(DW'(221), 1'b0);
        send_beat(DW'(222), 1'b1);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        for (int i = 0; i < 8; i++) send_beat(DW'(230 + i), 1'b0);
        drain();
        want = '{32'd205, 32'd217, 32'd222, 32'd237};
        cmp_log("t3_last", 1'b0);
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));

        // Length change mid-packet, then pkt_len=0
        clear_logs();
        pkt_len = LW'(2);
        send_beat(DW'(300), 1'b0);
        pkt_len = LW'(5);
        for (int i = 1; i < 7; i++) send_beat(DW'(300 + i), 1'b0);
        pkt_len = LW'(0);
        for (int i = 0; i < 3; i++) send_beat(DW'(310 + i), 1'b0);
        drain();
        want = '{32'd301, 32'd306, 32'd310, 32'd311, 32'd312};
        cmp_log("t4_last", 1'b0);

        // Reset mid-packet with output stalled
        clear_logs();
        pkt_len    = LW'(4);
        hold_ready = 1'b1;
        send_beat(DW'(400), 1'b0);
        idle(1, 1'b0);
        hold_ready = 1'b0;
        send_beat(DW'(401), 1'b0);
        send_beat(DW'(402), 1'b0);
        @(negedge ps_clk);
        chk("t5_skid_full", 64'(s_tready), 64'(0));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge ps_clk);
        chk("t5_tvalid", 64'(m_tvalid), 64'(0));
        chk("t5_pkt_cnt_rst", 64'(pkt_cnt), 64'(0));
        chk("t5_ready_low", 64'(s_tready), 64'(0));
        step();
        @(negedge ps_clk);
        chk("t5_ready_high", 64'(s_tready), 64'(1));
        step();
        hold_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(DW'(410 + i), 1'b0);
        drain();
        want = '{32'd413};
        cmp_log("t5_last", 1'b0);
        want = '{32'd400, 32'd410, 32'd411, 32'd412, 32'd413};
        cmp_log("t5_out", 1'b1);
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'(1));

        // Counter wrap with 4-bit pkt_cnt
        do_reset();
        clear_logs();
        pkt_len = LW'(1);
        for (int i = 0; i < 17; i++) send_beat(DW'(500 + i), 1'b0);
        drain();
        chk("t6_pkt_cnt_wrap", 64'(pkt_cnt), 64'(1));
        chk("t6_pkt_cnt_model", 64'(pkt_cnt), 64'(m_pkt));
        chk("t6_last_count", 64'(last_log.size()), 64'(17));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
